// File: rtl/multi_timer_pkg.sv
// Shared types and width helpers for the multi-channel countdown timer.
// Holds the per-channel state enum, the progress level codes driven to the
// RGB LED driver, and the width functions used by the top and the channels.
package multi_timer_pkg;

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_ALARM = 2'd2
   } state_t;

   localparam logic [1:0] LVL_IDLE = 2'd0;  // channel not running
   localparam logic [1:0] LVL_HIGH = 2'd1;  // more than half left
   localparam logic [1:0] LVL_MID  = 2'd2;  // 20..50 % left
   localparam logic [1:0] LVL_LOW  = 2'd3;  // 20 % or less left

   // Channel select width; a single channel still gets a 1-bit select.
   function automatic int f_ch_w(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

   // Width holding the largest total seconds value (MAX_MIN:59).
   function automatic int f_tot_w(input int max_min);
      return $clog2(max_min * 60 + 60);
   endfunction

   // Width of a counter that must hold 0..n-1 (at least one bit).
   function automatic int f_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: minute/second editing, start/pause, second tick
// divider, expiry with optional auto-reload, alarm with self-clear timer and
// the progress level. Buttons arrive already gated by the channel select.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   i_btn_min/sec/ss/rst     button pulses routed to this channel
//   i_repeat_en              auto-reload enable, sampled at expiry
//   o_min, o_sec             remaining time
//   o_preset_min/sec         latched start value
//   o_run, o_alarm           state flags
//   o_expire_p               one-cycle expiry pulse (registered)
//   o_level                  progress level, LVL_IDLE unless running
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_STOP  | idle or paused; min/sec buttons edit the time
// ST_RUN   | counting down one second per TICK_DIV cycles
// ST_ALARM | expired at 0:00, waiting for a button or the self-clear
module timer_channel
   import multi_timer_pkg::*;
#(
   parameter int TICK_DIV  = 1000,
   parameter int MAX_MIN   = 59,
   parameter int ALARM_SEC = 30,
   parameter int TOT_W     = f_tot_w(MAX_MIN)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_min,
   input  logic       i_btn_sec,
   input  logic       i_btn_ss,
   input  logic       i_btn_rst,
   input  logic       i_repeat_en,
   output logic [6:0] o_min,
   output logic [5:0] o_sec,
   output logic [6:0] o_preset_min,
   output logic [5:0] o_preset_sec,
   output logic       o_run,
   output logic       o_alarm,
   output logic       o_expire_p,
   output logic [1:0] o_level
);

   localparam int TK_W = f_cnt_w(TICK_DIV);
   localparam int AL_W = f_cnt_w(ALARM_SEC + 1);
   localparam int PW   = TOT_W + 3;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [6:0]        r_min;
   logic [5:0]        r_sec;
   logic [6:0]        r_pmin;
   logic [5:0]        r_psec;
   logic [TK_W-1:0]   r_tick;
   logic [AL_W-1:0]   r_al_cnt;
   logic              r_edited;
   logic              r_expire_p;

   logic              w_zero;
   logic              w_preset_zero;
   logic              w_wrap;
   logic              w_start;
   logic              w_expire;
   logic              w_alarm_clr;
   logic              w_alarm_to;
   logic [PW-1:0]     w_rem;
   logic [PW-1:0]     w_pre;

   assign w_zero        = (r_min == 7'd0) && (r_sec == 6'd0);
   assign w_preset_zero = (r_pmin == 7'd0) && (r_psec == 6'd0);
   assign w_wrap        = (r_tick == TK_W'(TICK_DIV - 1));
   assign w_start       = (r_state == ST_STOP) && i_btn_ss && !w_zero;
   // A pause or reset landing on the wrap cycle suppresses the expiry.
   assign w_expire      = (r_state == ST_RUN) && !i_btn_rst && !i_btn_ss && w_wrap &&
                          (r_min == 7'd0) && (r_sec == 6'd1);
   assign w_alarm_clr   = i_btn_min | i_btn_sec | i_btn_ss;
   // Down-counter loaded with ALARM_SEC at expiry; terminal count is the
   // wrap that sees 1 left. ALARM_SEC = 0 disables the self-clear.
   assign w_alarm_to    = (ALARM_SEC > 0) && (r_state == ST_ALARM) && w_wrap &&
                          (r_al_cnt == AL_W'(1));

   assign w_rem = PW'(r_min) * PW'(60) + PW'(r_sec);
   assign w_pre = PW'(r_pmin) * PW'(60) + PW'(r_psec);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_STOP;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (i_btn_rst) begin
         w_state_nxt = ST_STOP;
      end else begin
         case (r_state)
            ST_STOP:  if (w_start) w_state_nxt = ST_RUN;
            ST_RUN: begin
               if (i_btn_ss)                      w_state_nxt = ST_STOP;
               else if (w_expire && !i_repeat_en) w_state_nxt = ST_ALARM;
            end
            ST_ALARM: if (w_alarm_clr || w_alarm_to) w_state_nxt = ST_STOP;
            default:  w_state_nxt = ST_STOP;
         endcase
      end
   end

   // Time, preset, tick and alarm datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_min      <= 7'd0;
         r_sec      <= 6'd0;
         r_pmin     <= 7'd0;
         r_psec     <= 6'd0;
         r_tick     <= '0;
         r_al_cnt   <= '0;
         r_edited   <= 1'b0;
         r_expire_p <= 1'b0;
      end else begin
         r_expire_p <= w_expire;
         if (i_btn_rst) begin
            r_min    <= 7'd0;
            r_sec    <= 6'd0;
            r_pmin   <= 7'd0;
            r_psec   <= 6'd0;
            r_tick   <= '0;
            r_al_cnt <= '0;
            r_edited <= 1'b0;
         end else begin
            case (r_state)
               ST_STOP: begin
                  r_tick <= '0;
                  if (w_start) begin
                     // A plain resume after a pause keeps the old preset.
                     if (w_preset_zero || r_edited) begin
                        r_pmin <= r_min;
                        r_psec <= r_sec;
                     end
                     r_edited <= 1'b0;
                  end else if (i_btn_min) begin
                     r_min    <= (r_min == 7'(MAX_MIN)) ? 7'd0 : r_min + 7'd1;
                     r_edited <= 1'b1;
                  end else if (i_btn_sec) begin
                     r_sec    <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
                     r_edited <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (i_btn_ss) begin
                     r_tick <= '0;
                  end else begin
                     r_tick <= w_wrap ? '0 : r_tick + TK_W'(1);
                     if (w_expire) begin
                        if (i_repeat_en) begin
                           r_min <= r_pmin;
                           r_sec <= r_psec;
                        end else begin
                           r_min    <= 7'd0;
                           r_sec    <= 6'd0;
                           r_al_cnt <= AL_W'(ALARM_SEC);
                        end
                     end else if (w_wrap) begin
                        if (r_sec == 6'd0) begin
                           r_sec <= 6'd59;
                           r_min <= r_min - 7'd1;
                        end else begin
                           r_sec <= r_sec - 6'd1;
                        end
                     end
                  end
               end
               ST_ALARM: begin
                  if (w_alarm_clr) begin
                     r_tick <= '0;
                  end else begin
                     r_tick <= w_wrap ? '0 : r_tick + TK_W'(1);
                     if (w_wrap && (r_al_cnt != '0)) r_al_cnt <= r_al_cnt - AL_W'(1);
                  end
               end
               default: r_tick <= '0;
            endcase
         end
      end
   end

   // Outputs
   always_comb begin
      o_run   = 1'b0;
      o_alarm = 1'b0;
      o_level = LVL_IDLE;
      case (r_state)
         ST_RUN: begin
            o_run = 1'b1;
            if (w_rem * PW'(5) <= w_pre)    o_level = LVL_LOW;
            else if (w_rem * PW'(2) > w_pre) o_level = LVL_HIGH;
            else                             o_level = LVL_MID;
         end
         ST_ALARM: o_alarm = 1'b1;
         default:  o_level = LVL_IDLE;
      endcase
   end

   assign o_min        = r_min;
   assign o_sec        = r_sec;
   assign o_preset_min = r_pmin;
   assign o_preset_sec = r_psec;
   assign o_expire_p   = r_expire_p;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel countdown timer top. Routes the shared button pulses to the
// selected channel, muxes the selected channel onto the display/LED outputs
// and collects per-channel run/alarm/expiry flags. All channels count
// independently in the background.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   sel                              selected channel (>= N_CH selects none)
//   btn_min_p, btn_sec_p,
//   btn_start_stop_p, btn_reset_p    single-cycle button pulses
//   repeat_en                        per-channel auto-reload enable
//   disp_min, disp_sec               remaining time of selected channel
//   preset_min, preset_sec           preset of selected channel
//   run, alarm, expire_p             per-channel flags
//   alarm_any                        OR of alarm
//   level                            progress level of selected channel
module multi_timer
   import multi_timer_pkg::*;
#(
   parameter int   N_CH      = 4,
   parameter int   TICK_DIV  = 1000,
   parameter int   MAX_MIN   = 59,
   parameter int   ALARM_SEC = 30,
   localparam int  CH_W      = f_ch_w(N_CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [CH_W-1:0] sel,
   input  logic            btn_min_p,
   input  logic            btn_sec_p,
   input  logic            btn_start_stop_p,
   input  logic            btn_reset_p,
   input  logic [N_CH-1:0] repeat_en,
   output logic [6:0]      disp_min,
   output logic [5:0]      disp_sec,
   output logic [6:0]      preset_min,
   output logic [5:0]      preset_sec,
   output logic [N_CH-1:0] run,
   output logic [N_CH-1:0] alarm,
   output logic            alarm_any,
   output logic [N_CH-1:0] expire_p,
   output logic [1:0]      level
);

   localparam int TOT_W = f_tot_w(MAX_MIN);

   logic            w_sel_ok;
   logic [N_CH-1:0] w_hit;
   logic [6:0]      w_min  [N_CH];
   logic [5:0]      w_sec  [N_CH];
   logic [6:0]      w_pmin [N_CH];
   logic [5:0]      w_psec [N_CH];
   logic [1:0]      w_lvl  [N_CH];

   // Extra bit so that N_CH = 2**CH_W compares without overflow.
   assign w_sel_ok = ({1'b0, sel} < (CH_W + 1)'(N_CH));

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign w_hit[g] = w_sel_ok && (sel == CH_W'(g));

      timer_channel #(
         .TICK_DIV  (TICK_DIV),
         .MAX_MIN   (MAX_MIN),
         .ALARM_SEC (ALARM_SEC),
         .TOT_W     (TOT_W)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .i_btn_min    (btn_min_p        & w_hit[g]),
         .i_btn_sec    (btn_sec_p        & w_hit[g]),
         .i_btn_ss     (btn_start_stop_p & w_hit[g]),
         .i_btn_rst    (btn_reset_p      & w_hit[g]),
         .i_repeat_en  (repeat_en[g]),
         .o_min        (w_min[g]),
         .o_sec        (w_sec[g]),
         .o_preset_min (w_pmin[g]),
         .o_preset_sec (w_psec[g]),
         .o_run        (run[g]),
         .o_alarm      (alarm[g]),
         .o_expire_p   (expire_p[g]),
         .o_level      (w_lvl[g])
      );
   end

   // At most one w_hit bit is set, so the loop acts as a one-hot mux.
   always_comb begin
      disp_min   = 7'd0;
      disp_sec   = 6'd0;
      preset_min = 7'd0;
      preset_sec = 6'd0;
      level      = LVL_IDLE;
      for (int i = 0; i < N_CH; i++) begin
         if (w_hit[i]) begin
            disp_min   = w_min[i];
            disp_sec   = w_sec[i];
            preset_min = w_pmin[i];
            preset_sec = w_psec[i];
            level      = w_lvl[i];
         end
      end
   end

   assign alarm_any = |alarm;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer with TICK_DIV=4, ALARM_SEC=2.
module tb_multi_timer;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] sel;
   logic       btn_min_p, btn_sec_p, btn_start_stop_p, btn_reset_p;
   logic [3:0] repeat_en;
   logic [6:0] disp_min, preset_min;
   logic [5:0] disp_sec, preset_sec;
   logic [3:0] run, alarm, expire_p;
   logic       alarm_any;
   logic [1:0] level;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int          k;
      logic [17:0] v;
   } sb_t;
   sb_t sb[$];

   multi_timer #(
      .N_CH(4), .TICK_DIV(4), .MAX_MIN(59), .ALARM_SEC(2)
   ) dut (
      .clk(clk), .rst(rst), .sel(sel),
      .btn_min_p(btn_min_p), .btn_sec_p(btn_sec_p),
      .btn_start_stop_p(btn_start_stop_p), .btn_reset_p(btn_reset_p),
      .repeat_en(repeat_en),
      .disp_min(disp_min), .disp_sec(disp_sec),
      .preset_min(preset_min), .preset_sec(preset_sec),
      .run(run), .alarm(alarm), .alarm_any(alarm_any),
      .expire_p(expire_p), .level(level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [1:0] exp_lvl(input int rem, input int pre, input bit running);
      if (!running)       return 2'd0;
      if (rem * 5 <= pre) return 2'd3;
      if (rem * 2 > pre)  return 2'd1;
      return 2'd2;
   endfunction

   function automatic logic [17:0] pk(input int m, input int s, input logic [1:0] l,
                                      input bit r, input bit a, input bit e);
      return {m[6:0], s[5:0], l, r, a, e};
   endfunction

   function automatic logic [17:0] obs(input int ch);
      return {disp_min, disp_sec, level, run[ch], alarm[ch], expire_p[ch]};
   endfunction

   task automatic press(input bit m, input bit s, input bit ss, input bit r);
      @(negedge clk);
      btn_min_p = m; btn_sec_p = s; btn_start_stop_p = ss; btn_reset_p = r;
      @(negedge clk);
      btn_min_p = 0; btn_sec_p = 0; btn_start_stop_p = 0; btn_reset_p = 0;
   endtask

   task automatic press_n(input bit m, input bit s, input int n);
      for (int i = 0; i < n; i++) press(m, s, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({disp_min, disp_sec, preset_min, preset_sec, level, run, alarm, alarm_any, expire_p} !== '0) begin
         bad++;
         $display("FAIL reset_hold got m=%0d s=%0d run=%b alarm=%b exp=%b want all zero",
                  disp_min, disp_sec, run, alarm, expire_p);
      end
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         sel = 2'(c);
         @(negedge clk);
         total++;
         if ({disp_min, disp_sec, preset_min, preset_sec, level, run, alarm} !== '0) begin
            bad++;
            $display("FAIL reset_ch%0d got m=%0d s=%0d pm=%0d ps=%0d run=%b want 0", c,
                     disp_min, disp_sec, preset_min, preset_sec, run);
         end
      end
   endtask

   // Channel 0 one-shot 0:03, then alarm self-clear after 2 tick wraps.
   task automatic test_oneshot;
      sb_t e;
      logic [17:0] o;
      int rem;
      sel = 2'd0;
      press_n(1'b0, 1'b1, 3);
      total++;
      if ({disp_min, disp_sec, preset_sec} !== {7'd0, 6'd3, 6'd0}) begin
         bad++;
         $display("FAIL oneshot_edit got %0d:%0d preset_s=%0d want 0:3 preset_s=0", disp_min, disp_sec, preset_sec);
      end
      press(1'b0, 1'b0, 1'b1, 1'b0);
      total++;
      if ({run[0], preset_sec} !== {1'b1, 6'd3}) begin
         bad++;
         $display("FAIL oneshot_start got run=%b preset_s=%0d want run=1 preset_s=3", run[0], preset_sec);
      end
      for (int k = 1; k <= 21; k++) begin
         rem = 3 - k / 4;
         if (k < 12)       sb.push_back('{k, pk(0, rem, exp_lvl(rem, 3, 1), 1, 0, 0)});
         else if (k == 12) sb.push_back('{k, pk(0, 0, 2'd0, 0, 1, 1)});
         else if (k < 20)  sb.push_back('{k, pk(0, 0, 2'd0, 0, 1, 0)});
         else              sb.push_back('{k, pk(0, 0, 2'd0, 0, 0, 0)});
      end
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].k == k) begin
            e = sb.pop_front();
            o = obs(0);
            total++;
            if (o !== e.v) begin
               bad++;
               $display("FAIL oneshot k=%0d got=%b want=%b (min|sec|lvl|run|alm|exp)", k, o, e.v);
            end
         end
      end
   endtask

   // Channel 1 auto-reload from 0:02 through three expiries.
   task automatic test_repeat;
      sb_t e;
      logic [17:0] o;
      int pulses = 0;
      int ph;
      sel = 2'd1;
      repeat_en = 4'b0010;
      press_n(1'b0, 1'b1, 2);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 24; k++) begin
         ph = k % 8;
         if (ph >= 4) sb.push_back('{k, pk(0, 1, exp_lvl(1, 2, 1), 1, 0, 0)});
         else         sb.push_back('{k, pk(0, 2, exp_lvl(2, 2, 1), 1, 0, (ph == 0))});
      end
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (expire_p[1]) pulses++;
         while (sb.size() > 0 && sb[0].k == k) begin
            e = sb.pop_front();
            o = obs(1);
            total++;
            if (o !== e.v) begin
               bad++;
               $display("FAIL repeat k=%0d got=%b want=%b (min|sec|lvl|run|alm|exp)", k, o, e.v);
            end
         end
      end
      total++;
      if (pulses != 3) begin
         bad++;
         $display("FAIL repeat_pulses got %0d want 3", pulses);
      end
      press(1'b0, 1'b0, 1'b1, 1'b0);
      repeat_en = 4'b0000;
      total++;
      if ({run[1], preset_sec} !== {1'b0, 6'd2}) begin
         bad++;
         $display("FAIL repeat_stop got run=%b preset_s=%0d want run=0 preset_s=2", run[1], preset_sec);
      end
   endtask

   // Channel 2: pause at 0:05, hold, resume, then pause on a wrap cycle.
   task automatic test_pause;
      sb_t e;
      logic [17:0] o;
      int rem;
      sel = 2'd2;
      press_n(1'b0, 1'b1, 7);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         rem = 7 - k / 4;
         sb.push_back('{k, pk(0, rem, exp_lvl(rem, 7, 1), 1, 0, 0)});
      end
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].k == k) begin
            e = sb.pop_front();
            o = obs(2);
            total++;
            if (o !== e.v) begin
               bad++;
               $display("FAIL pause_run k=%0d got=%b want=%b (min|sec|lvl|run|alm|exp)", k, o, e.v);
            end
         end
      end
      press(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 20; k++) sb.push_back('{k, pk(0, 5, 2'd0, 0, 0, 0)});
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].k == k) begin
            e = sb.pop_front();
            o = obs(2);
            total++;
            if (o !== e.v) begin
               bad++;
               $display("FAIL pause_hold k=%0d got=%b want=%b (min|sec|lvl|run|alm|exp)", k, o, e.v);
            end
         end
      end
      press(1'b0, 1'b0, 1'b1, 1'b0);
      total++;
      if ({preset_min, preset_sec} !== {7'd0, 6'd7}) begin
         bad++;
         $display("FAIL pause_preset got %0d:%0d want 0:7", preset_min, preset_sec);
      end
      for (int k = 1; k <= 6; k++) begin
         rem = (k < 4) ? 5 : 4;
         sb.push_back('{k, pk(0, rem, exp_lvl(rem, 7, 1), 1, 0, 0)});
      end
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].k == k) begin
            e = sb.pop_front();
            o = obs(2);
            total++;
            if (o !== e.v) begin
               bad++;
               $display("FAIL resume k=%0d got=%b want=%b (min|sec|lvl|run|alm|exp)", k, o, e.v);
            end
         end
      end
      // Pulse lands on the 8th edge after resume, which is a tick wrap.
      press(1'b0, 1'b0, 1'b1, 1'b0);
      total++;
      if ({disp_min, disp_sec, run[2]} !== {7'd0, 6'd4, 1'b0}) begin
         bad++;
         $display("FAIL pause_on_wrap got %0d:%0d run=%b want 0:4 run=0", disp_min, disp_sec, run[2]);
      end
   endtask

   // Reset one running channel while another keeps counting.
   task automatic test_reset_btn;
      int t3;
      int rem;
      sel = 2'd3;
      press_n(1'b0, 1'b1, 9);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      t3 = cyc;
      sel = 2'd2;
      press(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      press(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if ({disp_min, disp_sec, preset_min, preset_sec, run[2], run[3]} !== {7'd0, 6'd0, 7'd0, 6'd0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL reset_btn got %0d:%0d preset %0d:%0d run=%b want 0:0 preset 0:0 run=1000",
                  disp_min, disp_sec, preset_min, preset_sec, run);
      end
      sel = 2'd3;
      for (int n = 0; n < 2; n++) begin
         repeat (5) @(negedge clk);
         rem = 9 - (cyc - t3) / 4;
         total++;
         if ({disp_min, disp_sec, run[3]} !== {7'd0, 6'(rem), 1'b1}) begin
            bad++;
            $display("FAIL other_ch_counting got %0d:%0d run=%b want 0:%0d run=1", disp_min, disp_sec, run[3], rem);
         end
      end
   endtask

   task automatic test_async_rst;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({disp_min, disp_sec, preset_min, preset_sec, level, run, alarm, alarm_any, expire_p} !== '0) begin
         bad++;
         $display("FAIL async_rst_now got m=%0d s=%0d run=%b want all zero", disp_min, disp_sec, run);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      for (int c = 0; c < 4; c++) begin
         sel = 2'(c);
         #1;
         total++;
         if ({disp_min, disp_sec, preset_min, preset_sec, run, alarm} !== '0) begin
            bad++;
            $display("FAIL async_rst_ch%0d got %0d:%0d preset %0d:%0d run=%b want zero", c,
                     disp_min, disp_sec, preset_min, preset_sec, run);
         end
      end
   endtask

   task automatic test_wrap;
      sel = 2'd0;
      press_n(1'b1, 1'b0, 59);
      total++;
      if ({disp_min, disp_sec} !== {7'd59, 6'd0}) begin
         bad++;
         $display("FAIL min_59 got %0d:%0d want 59:0", disp_min, disp_sec);
      end
      press(1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if ({disp_min, disp_sec} !== {7'd0, 6'd0}) begin
         bad++;
         $display("FAIL min_wrap got %0d:%0d want 0:0", disp_min, disp_sec);
      end
      press(1'b1, 1'b1, 1'b0, 1'b0);
      total++;
      if ({disp_min, disp_sec} !== {7'd1, 6'd0}) begin
         bad++;
         $display("FAIL min_sec_same got %0d:%0d want 1:0", disp_min, disp_sec);
      end
      press_n(1'b0, 1'b1, 60);
      total++;
      if ({disp_min, disp_sec} !== {7'd1, 6'd0}) begin
         bad++;
         $display("FAIL sec_wrap got %0d:%0d want 1:0", disp_min, disp_sec);
      end
   endtask

   // Channel 1 one-shot 0:01: edit ignored while running, alarm cleared by button.
   task automatic test_alarm_btn;
      sel = 2'd1;
      press(1'b0, 1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if ({disp_min, disp_sec, run[1]} !== {7'd0, 6'd1, 1'b1}) begin
         bad++;
         $display("FAIL edit_in_run got %0d:%0d run=%b want 0:1 run=1", disp_min, disp_sec, run[1]);
      end
      repeat (2) @(negedge clk);
      total++;
      if ({disp_min, disp_sec, alarm[1], alarm_any, run[1]} !== {7'd0, 6'd0, 1'b1, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL alarm_enter got %0d:%0d alarm=%b any=%b run=%b want 0:0 alarm=1 any=1 run=0",
                  disp_min, disp_sec, alarm[1], alarm_any, run[1]);
      end
      press(1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if ({disp_min, disp_sec, alarm[1], alarm_any, run[1]} !== {7'd0, 6'd0, 1'b0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL alarm_clear got %0d:%0d alarm=%b any=%b run=%b want 0:0 all flags 0",
                  disp_min, disp_sec, alarm[1], alarm_any, run[1]);
      end
   endtask

   initial begin
      rst = 1'b1;
      sel = 2'd0;
      btn_min_p = 0; btn_sec_p = 0; btn_start_stop_p = 0; btn_reset_p = 0;
      repeat_en = 4'b0000;
      test_reset;
      test_oneshot;
      test_repeat;
      test_pause;
      test_reset_btn;
      test_async_rst;
      test_wrap;
      test_alarm_btn;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
